// File: rtl/mem_access_unit_if.sv
// EX -> MEM -> WB handshake and data-memory bus bundle for the MEM stage.
// The slave modport is the stage's view; master is the surrounding pipeline and memory.
interface mem_access_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MEM_AW = 3,
  parameter int unsigned REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;

  logic              mem_write;
  logic              mem_read;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic              out_err;

  modport slave (
    input  in_valid, in_op, in_addr, in_wdata, in_rd, in_reg_write, mem_rdata, out_ready,
    output in_ready, mem_write, mem_read, mem_addr, mem_wdata,
    output out_valid, out_result, out_rd, out_reg_write, out_err
  );

  modport master (
    output in_valid, in_op, in_addr, in_wdata, in_rd, in_reg_write, mem_rdata, out_ready,
    input  in_ready, mem_write, mem_read, mem_addr, mem_wdata,
    input  out_valid, out_result, out_rd, out_reg_write, out_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM stage of the 16-bit MIPS datapath: one EX result per handshake, one-cycle memory
// strobe for load/store, registered MEM/WB result held until writeback accepts it.
module mem_access_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned MEM_AW = 3,
  parameter int unsigned REG_AW = 3
) (
  input logic            clk,
  input logic            rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [1:0] OpPass  = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;
  localparam logic [1:0] OpRsvd  = 2'b11;

  state_e            r_state;
  state_e            w_state_next;
  logic [1:0]        r_op;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_rd;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_result;
  logic              r_out_reg_write;
  logic              r_err;

  logic w_accept;
  logic w_is_mem_op;
  logic w_fault;
  logic w_in_ready;
  logic w_out_valid;
  logic w_mem_read;
  logic w_mem_write;

  assign w_accept    = (r_state == StIdle) && bus.in_valid;
  assign w_is_mem_op = (bus.in_op == OpLoad) || (bus.in_op == OpStore);
  assign w_fault     = (bus.in_op == OpRsvd) ||
                       (w_is_mem_op && (|bus.in_addr[ADDR_W-1:MEM_AW]));

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = (w_fault || (bus.in_op == OpPass)) ? StResp : StAccess;
        end
      end
      StAccess: begin
        w_mem_read   = (r_op == OpLoad);
        // Gated by rst_n so a store never commits on an edge while reset is held.
        w_mem_write  = (r_op == OpStore) && rst_n;
        w_state_next = StResp;
      end
      StResp: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op            <= OpPass;
      r_reg_write     <= 1'b0;
      r_rd            <= '0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_result        <= '0;
      r_out_reg_write <= 1'b0;
      r_err           <= 1'b0;
    end else if (w_accept) begin
      r_op        <= bus.in_op;
      r_reg_write <= bus.in_reg_write;
      r_rd        <= bus.in_rd;
      if (w_fault) begin
        r_result        <= '0;
        r_out_reg_write <= 1'b0;
        r_err           <= 1'b1;
      end else if (bus.in_op == OpPass) begin
        r_result        <= DATA_W'(bus.in_addr);
        r_out_reg_write <= bus.in_reg_write;
        r_err           <= 1'b0;
      end else begin
        // Memory-side address/data only move for real accesses, so they hold while idle.
        r_mem_addr      <= bus.in_addr[MEM_AW-1:0];
        r_mem_wdata     <= bus.in_wdata;
        r_result        <= '0;
        r_out_reg_write <= 1'b0;
        r_err           <= 1'b0;
      end
    end else if (r_state == StAccess) begin
      if (r_op == OpLoad) begin
        r_result        <= bus.mem_rdata;
        r_out_reg_write <= r_reg_write;
      end else begin
        r_result        <= '0;
        r_out_reg_write <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.out_result    = r_result;
  assign bus.out_rd        = r_rd;
  assign bus.out_reg_write = r_out_reg_write;
  assign bus.out_err       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural 8-word data memory and a queue of
// expected MEM/WB results filled at stimulus time and drained at each writeback handshake.
module tb_mem_access_unit;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  rd;
    logic        rw;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cyc;
  int   n_rd;
  int   n_wr;
  logic [2:0] last_raddr;
  exp_t sb[$];

  logic [15:0] tb_mem [8];
  logic        mem_clr;
  logic        pl_en;
  logic [2:0]  pl_addr;
  logic [15:0] pl_data;

  mem_access_unit_if bus ();

  mem_access_unit u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) tb_mem[i] <= 16'h0000;
    end else if (pl_en) begin
      tb_mem[pl_addr] <= pl_data;
    end else if (bus.mem_write) begin
      tb_mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  assign bus.mem_rdata = bus.mem_read ? tb_mem[bus.mem_addr] : 16'h0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_read) begin
      n_rd       <= n_rd + 1;
      last_raddr <= bus.mem_addr;
    end
    if (bus.mem_write) n_wr <= n_wr + 1;
    if (bus.mem_read && bus.mem_write) begin
      $display("FAIL strobe_exclusive: read=%b write=%b required not both 1",
               bus.mem_read, bus.mem_write);
      failures <= failures + 1;
    end
  end

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive_in(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [2:0] rd, input logic rw);
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_addr = addr;
    bus.in_wdata = wd; bus.in_rd = rd; bus.in_reg_write = rw;
  endtask

  // One transaction with a single writeback handshake; expected values come from the caller.
  task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [2:0] rd, input logic rw,
                        input logic [15:0] e_res, input logic e_rw, input logic e_err,
                        input int e_lat, input int e_rdp, input int e_wrp);
    int   rd0, wr0, waited;
    exp_t e;
    sb.push_back('{res: e_res, rd: rd, rw: e_rw, err: e_err});
    rd0 = n_rd; wr0 = n_wr;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL %s_in_ready: got %b want 1", name, bus.in_ready); failures++;
    end
    drive_in(op, addr, wd, rd, rw);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    waited = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    e = sb.pop_front();
    checks++;
    if (waited >= 20) begin
      $display("FAIL %s_timeout: out_valid never rose", name); failures++;
      return;
    end
    if (waited != e_lat) begin
      $display("FAIL %s_latency: got %0d want %0d", name, waited, e_lat); failures++;
    end
    checks += 4;
    if (bus.out_result !== e.res) begin
      $display("FAIL %s_result: got %h want %h", name, bus.out_result, e.res); failures++;
    end
    if (bus.out_rd !== e.rd) begin
      $display("FAIL %s_rd: got %0d want %0d", name, bus.out_rd, e.rd); failures++;
    end
    if (bus.out_reg_write !== e.rw) begin
      $display("FAIL %s_reg_write: got %b want %b", name, bus.out_reg_write, e.rw); failures++;
    end
    if (bus.out_err !== e.err) begin
      $display("FAIL %s_err: got %b want %b", name, bus.out_err, e.err); failures++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    checks += 3;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL %s_post_hs: in_ready=%b out_valid=%b want 1/0", name, bus.in_ready,
               bus.out_valid);
      failures++;
    end
    if (n_rd - rd0 != e_rdp) begin
      $display("FAIL %s_read_pulses: got %0d want %0d", name, n_rd - rd0, e_rdp); failures++;
    end
    if (n_wr - wr0 != e_wrp) begin
      $display("FAIL %s_write_pulses: got %0d want %0d", name, n_wr - wr0, e_wrp); failures++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mem_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_result !== 16'h0 ||
        bus.out_rd !== 3'd0 || bus.out_reg_write !== 1'b0 || bus.out_err !== 1'b0 ||
        bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_addr !== 3'd0 ||
        bus.mem_wdata !== 16'h0) begin
      $display("FAIL reset_state: rdy=%b vld=%b res=%h rd=%0d rw=%b err=%b we=%b re=%b a=%0d",
               bus.in_ready, bus.out_valid, bus.out_result, bus.out_rd, bus.out_reg_write,
               bus.out_err, bus.mem_write, bus.mem_read, bus.mem_addr);
      failures++;
    end
    // Reset in the middle of a store's ACCESS cycle.
    drive_in(2'b10, 16'h0003, 16'h1234, 3'd1, 1'b0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    checks++;
    if (bus.mem_write !== 1'b1 || bus.mem_addr !== 3'd3) begin
      $display("FAIL reset_store_started: we=%b addr=%0d want 1/3", bus.mem_write, bus.mem_addr);
      failures++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_write !== 1'b0) begin
      $display("FAIL reset_we_drop: got %b want 0", bus.mem_write); failures++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (tb_mem[3] !== 16'h0000) begin
      $display("FAIL reset_no_commit: mem[3]=%h want 0000", tb_mem[3]); failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || tb_mem[3] !== 16'h0000) begin
      $display("FAIL reset_release: in_ready=%b out_valid=%b mem[3]=%h want 1/0/0000",
               bus.in_ready, bus.out_valid, tb_mem[3]);
      failures++;
    end
  endtask

  task automatic test_load();
    preload(3'd1, 16'h0006);
    run_op("load", 2'b01, 16'h0001, 16'h0, 3'd2, 1'b1, 16'h0006, 1'b1, 1'b0, 1, 1, 0);
    checks++;
    if (last_raddr !== 3'd1) begin
      $display("FAIL load_mem_addr: got %0d want 1", last_raddr); failures++;
    end
  endtask

  task automatic test_store_load();
    run_op("store7", 2'b10, 16'h0007, 16'hBEEF, 3'd4, 1'b1, 16'h0000, 1'b0, 1'b0, 1, 0, 1);
    checks++;
    if (tb_mem[7] !== 16'hBEEF) begin
      $display("FAIL store7_commit: mem[7]=%h want beef", tb_mem[7]); failures++;
    end
    run_op("load7", 2'b01, 16'h0007, 16'h0, 3'd5, 1'b1, 16'hBEEF, 1'b1, 1'b0, 1, 1, 0);
  endtask

  task automatic test_faults();
    run_op("oor_load", 2'b01, 16'h0008, 16'h0, 3'd3, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 0, 0);
    run_op("oor_store", 2'b10, 16'h8002, 16'hFFFF, 3'd6, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 0, 0);
    run_op("reserved", 2'b11, 16'h0002, 16'h1111, 3'd7, 1'b1, 16'h0000, 1'b0, 1'b1, 0, 0, 0);
    checks++;
    if (tb_mem[2] !== 16'h0000) begin
      $display("FAIL fault_no_write: mem[2]=%h want 0000", tb_mem[2]); failures++;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    sb.push_back('{res: 16'h00A5, rd: 3'd5, rw: 1'b1, err: 1'b0});
    @(negedge clk);
    drive_in(2'b00, 16'h00A5, 16'h0, 3'd5, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_result !== e.res ||
          bus.out_rd !== e.rd || bus.out_reg_write !== e.rw || bus.out_err !== e.err) begin
        $display("FAIL bp_hold[%0d]: vld=%b rdy=%b res=%h rd=%0d rw=%b err=%b want 1/0/%h/%0d/%b/%b",
                 i, bus.out_valid, bus.in_ready, bus.out_result, bus.out_rd, bus.out_reg_write,
                 bus.out_err, e.res, e.rd, e.rw, e.err);
        failures++;
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", bus.in_ready,
               bus.out_valid);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ops [5]   = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00};
    logic [15:0] addrs [5] = '{16'h0011, 16'h0022, 16'h0007, 16'h0000, 16'h0033};
    logic [15:0] res [5]   = '{16'h0011, 16'h0022, 16'hBEEF, 16'h0000, 16'h0033};
    logic        rws [5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        erws [5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          gaps [4]  = '{2, 2, 3, 3};
    int          acc [5];
    bus.out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          int w;
          w = 0;
          @(negedge clk);
          while (bus.in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
          end
          sb.push_back('{res: res[i], rd: 3'(i), rw: erws[i], err: 1'b0});
          drive_in(ops[i], addrs[i], 16'h5A5A, 3'(i), rws[i]);
          @(posedge clk);
          #1 acc[i] = cyc;
          bus.in_valid = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 5; i++) begin
          int   w;
          exp_t e;
          w = 0;
          @(negedge clk);
          while (bus.out_valid !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
          end
          checks++;
          if (w >= 40 || sb.size() == 0) begin
            $display("FAIL b2b_timeout[%0d]: no result", i); failures++;
          end else begin
            e = sb.pop_front();
            if (bus.out_result !== e.res || bus.out_rd !== e.rd ||
                bus.out_reg_write !== e.rw || bus.out_err !== e.err) begin
              $display("FAIL b2b_result[%0d]: res=%h rd=%0d rw=%b err=%b want %h/%0d/%b/%b", i,
                       bus.out_result, bus.out_rd, bus.out_reg_write, bus.out_err, e.res, e.rd,
                       e.rw, e.err);
              failures++;
            end
          end
          @(posedge clk);
        end
      end
    join
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc[i+1] - acc[i] != gaps[i]) begin
        $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, acc[i+1] - acc[i], gaps[i]);
        failures++;
      end
    end
    checks++;
    if (tb_mem[0] !== 16'h5A5A) begin
      $display("FAIL b2b_store: mem[0]=%h want 5a5a", tb_mem[0]); failures++;
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; n_rd = 0; n_wr = 0; last_raddr = 3'd0;
    pl_en = 1'b0; pl_addr = 3'd0; pl_data = 16'h0; mem_clr = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 2'b00; bus.in_addr = 16'h0; bus.in_wdata = 16'h0;
    bus.in_rd = 3'd0; bus.in_reg_write = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_load();
    test_store_load();
    test_faults();
    test_backpressure();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
